regfile_param: RTL
==================

Name: regfile_param

Overview:
- Parametrised successor to the fixed 32x32 register file, for the datapath's decode/writeback stage.
- Adds configurable width/depth, an optional hardwired zero register, and per-byte write enables.
- Adds optional write-to-read bypass and a multi-cycle soft-clear sequencer with a busy flag.
- Two combinational read ports and one synchronous write port.

Parameters:
- WIDTH, 32: data width in bits; must be a multiple of 8.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 1: 1 = register 0 reads as 0 and ignores writes.
- BYPASS, 1: 1 = a same-cycle write to a read address is forwarded to that read port.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- r  input  1  reset, asynchronous, active-low.
- dataIn  input  WIDTH  write data.
- rd  input  ADDR_W  write address.
- writeEn  input  1  write request.
- byteEn  input  WIDTH/8  per-byte write mask; bit i covers dataIn[8i+7:8i].
- rs1  input  ADDR_W  read address A.
- rs2  input  ADDR_W  read address B.
- dataA  output  WIDTH  read data A (combinational).
- dataB  output  WIDTH  read data B (combinational).
- clr  input  1  soft-clear start request.
- busy  output  1  soft-clear sweep in progress.
- writeDrop  output  1  combinational; = writeEn & busy.

Behaviour:
- Reset (r low, asynchronous):
  - All registers cleared to 0; FSM to IDLE; sweep pointer to 0; busy = 0.
  - dataA and dataB therefore read 0.
  - Reset asserted mid-sweep aborts the sweep immediately.
- Write qualification: a write is effective = writeEn & ~busy & ~(ZERO_REG & rd==0).
- Write execution: an effective write at a rising edge updates reg[rd] byte-wise.
  - Bytes with byteEn[i]=1 take dataIn; other bytes keep their old value.
  - byteEn all-zero: no change.
- Read: dataX = reg[rsX], purely combinational.
  - With ZERO_REG=1, rsX==0 always reads 0.
- Bypass (BYPASS=1): when a write is effective and rd==rsX, dataX = byte-merged new value in the same cycle.
  - The merge takes dataIn bytes where byteEn=1 and old reg[rd] bytes elsewhere.
  - Applies to both ports independently, including rs1==rs2==rd.
- Bypass off (BYPASS=0): dataX shows the old value until after the edge.
- Clear FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP when clr=1 at edge k; ptr=0; busy=1 after edge k.
  - The write presented at edge k is still performed, since busy was low.
  - In SWEEP, each edge zeroes reg[ptr] then ptr++. Edges k+1..k+DEPTH clear registers 0..DEPTH-1.
  - At edge k+DEPTH (ptr==DEPTH-1): FSM -> IDLE, ptr -> 0, busy -> 0. busy is high for exactly DEPTH cycles.
- clr asserted while in SWEEP is ignored; there is no restart and no queuing.
- Writes while busy: dropped, with writeDrop=1 for every cycle writeEn is high. No bypass occurs for dropped writes.
- Reads during SWEEP return current contents: registers already swept read 0, the rest keep their old values.
- No internal clock gating; all registers are in the clk domain.

Test Plan:
- Reset then read: r low 10 ns, release, rs1=1, rs2=31 -> dataA=dataB=0 and busy=0.
- Basic write/read:
  - Write 0x28111172 to rd=1 with byteEn=4'hF.
  - Write 0x22857572 to rd=2 with byteEn=4'hF.
  - Set rs1=1, rs2=2 -> dataA=0x28111172, dataB=0x22857572.
- Zero register and byte enables:
  - Write 0xFFFFFFFF to rd=0 -> reading rs1=0 gives 0.
  - reg1=0x28111172, then write 0xAABBCCDD with byteEn=4'b0101 -> reg1=0x28BB11DD.
- Bypass: reg3=0x11111111; in the same cycle write 0x12345678 to rd=3 (byteEn=4'hF) with rs1=rs2=3 -> dataA=dataB=0x12345678 before the edge. Repeat with BYPASS=0 -> both show 0x11111111 until after the edge.
- Soft clear:
  - Fill regs 1..31 with nonzero values, pulse clr for 1 cycle.
  - busy is high for exactly 32 cycles.
  - A writeEn to rd=5 during busy -> writeDrop=1 and reg5 ends at 0.
  - After busy falls, all registers read 0; a second clr during busy does not extend it.
- Reset mid-sweep: pulse clr, assert r low after 10 sweep cycles -> busy=0 immediately and all registers read 0. A subsequent write to rd=7 of 0x0000BEEF succeeds.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports, one byte-masked
// synchronous write port, optional zero register / write bypass, soft-clear sweep.
module regfile_param #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                 clk,
    input  logic                 r,
    input  logic [WIDTH-1:0]     dataIn,
    input  logic [ADDR_W-1:0]    rd,
    input  logic                 writeEn,
    input  logic [WIDTH/8-1:0]   byteEn,
    input  logic [ADDR_W-1:0]    rs1,
    input  logic [ADDR_W-1:0]    rs2,
    output logic [WIDTH-1:0]     dataA,
    output logic [WIDTH-1:0]     dataB,
    input  logic                 clr,
    output logic                 busy,
    output logic                 writeDrop
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = WIDTH / 8;
    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [WIDTH-1:0]  regs_q [DEPTH];

    logic              wr_eff;
    logic [WIDTH-1:0]  wdata_d;

    assign busy      = (state_q == SWEEP);
    assign writeDrop = writeEn & busy;
    assign wr_eff    = writeEn & ~busy & ~((ZERO_REG != 0) && (rd == '0));

    // New value of reg[rd]: enabled bytes from dataIn, the rest from the old contents.
    always_comb begin
        wdata_d = regs_q[rd];
        for (int i = 0; i < NB; i++) begin
            if (byteEn[i]) begin
                wdata_d[8*i +: 8] = dataIn[8*i +: 8];
            end
        end
    end

    function automatic logic [WIDTH-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic [WIDTH-1:0]  stored,
        input logic              fwd_en,
        input logic [ADDR_W-1:0] waddr,
        input logic [WIDTH-1:0]  wdata
    );
        logic [WIDTH-1:0] val;
        val = stored;
        if ((BYPASS != 0) && fwd_en && (waddr == addr)) begin
            val = wdata;
        end
        if ((ZERO_REG != 0) && (addr == '0)) begin
            val = '0;
        end
        return val;
    endfunction

    assign dataA = read_port(rs1, regs_q[rs1], wr_eff, rd, wdata_d);
    assign dataB = read_port(rs2, regs_q[rs2], wr_eff, rd, wdata_d);

    // Sweep: edge k arms it with ptr=0, the next DEPTH edges clear one register each.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_eff) begin
                        regs_q[rd] <= wdata_d;
                    end
                    if (clr) begin
                        state_q <= SWEEP;
                        ptr_q   <= '0;
                    end
                end
                SWEEP: begin
                    regs_q[ptr_q] <= '0;
                    if (ptr_q == PTR_LAST) begin
                        state_q <= IDLE;
                        ptr_q   <= '0;
                    end else begin
                        ptr_q <= ptr_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ptr_q   <= '0;
                end
            endcase
        end
    end
endmodule
